// File: rtl/output_buffer.sv
`default_nettype none
// ============================================================================
// output_buffer : deskews systolic-array result columns into aligned rows and
//                 buffers them in a first-word fall-through FIFO.
// Optional macro OUTBUF_SKEW_CHECK_EN adds a sticky o_skew_err output.
// Revision: 1.0
// ============================================================================
module output_buffer #(
  parameter int NUM_COLS   = 3,
  parameter int ACC_WIDTH  = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_COLS-1:0]           i_col_valid,
  input  logic [NUM_COLS*ACC_WIDTH-1:0] i_col_data,
  output logic                          o_rd_valid,
  input  logic                          i_rd_ready,
  output logic [NUM_COLS*ACC_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH:0]           o_count,
  output logic                          o_full,
  output logic                          o_overflow
`ifdef OUTBUF_SKEW_CHECK_EN
  ,
  output logic                          o_skew_err
`endif
);

  localparam int                  c_DEPTH    = 2 ** ADDR_WIDTH;
  localparam int                  c_ROW_W    = NUM_COLS * ACC_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_FULL_CNT = (ADDR_WIDTH + 1)'(c_DEPTH);

  logic [NUM_COLS-1:0] w_al_valid;
  logic [c_ROW_W-1:0]  w_al_data;

  // Column c lags column 0 by c cycles, so it is delayed by the remaining
  // NUM_COLS-1-c cycles to line every column up with the last one.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    localparam int c_STAGES = NUM_COLS - 1 - c;
    if (c_STAGES == 0) begin : g_pass
      assign w_al_valid[c]                        = i_col_valid[c];
      assign w_al_data[c*ACC_WIDTH +: ACC_WIDTH] = i_col_data[c*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      logic [c_STAGES-1:0]  r_v;
      logic [ACC_WIDTH-1:0] r_d [c_STAGES];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_v <= '0;
          for (int s = 0; s < c_STAGES; s++) r_d[s] <= '0;
        end else begin
          r_v[0] <= i_col_valid[c];
          r_d[0] <= i_col_data[c*ACC_WIDTH +: ACC_WIDTH];
          for (int s = 1; s < c_STAGES; s++) begin
            r_v[s] <= r_v[s-1];
            r_d[s] <= r_d[s-1];
          end
        end
      end

      assign w_al_valid[c]                        = r_v[c_STAGES-1];
      assign w_al_data[c*ACC_WIDTH +: ACC_WIDTH] = r_d[c_STAGES-1];
    end
  end

  logic [c_ROW_W-1:0]    r_mem [c_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;

  logic w_full, w_empty, w_pop, w_push_req, w_push, w_drop;

  assign w_full     = (r_count == c_FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_pop      = !w_empty && i_rd_ready;
  assign w_push_req = &w_al_valid;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_al_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef OUTBUF_SKEW_CHECK_EN
  logic w_partial;
  logic r_skew_err;

  assign w_partial = (|w_al_valid) && !(&w_al_valid);

  always_ff @(posedge i_clk) begin
    if (i_rst)          r_skew_err <= 1'b0;
    else if (w_partial) r_skew_err <= 1'b1;
  end

  assign o_skew_err = r_skew_err;
`else
  // Partial valid patterns simply never satisfy the push condition.
`endif

  assign o_rd_valid = !w_empty;
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_output_buffer.sv
`default_nettype none
// Bench for output_buffer: skewed-row driver plus a queue-based FIFO model.
module tb_output_buffer;

  localparam int NC    = 3;
  localparam int AW    = 16;
  localparam int ADDRW = 2;
  localparam int DEPTH = 4;
  localparam int RW    = NC * AW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NC-1:0]     col_valid = '0;
  logic [RW-1:0]     col_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [RW-1:0]     rd_data;
  logic [ADDRW:0]    count;
  logic              full;
  logic              overflow;
`ifdef OUTBUF_SKEW_CHECK_EN
  logic              skew_err;
`endif

  output_buffer #(.NUM_COLS(NC), .ACC_WIDTH(AW), .ADDR_WIDTH(ADDRW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_col_valid(col_valid),
    .i_col_data (col_data),
    .o_rd_valid (rd_valid),
    .i_rd_ready (rd_ready),
    .o_rd_data  (rd_data),
    .o_count    (count),
    .o_full     (full),
    .o_overflow (overflow)
`ifdef OUTBUF_SKEW_CHECK_EN
    ,
    .o_skew_err (skew_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Rows in flight, indexed by age in cycles; mask selects valid columns.
  logic [NC-1:0] hist_m [NC];
  logic [RW-1:0] hist_d [NC];

  logic [RW-1:0] q [$];
  logic          m_ovf  = 1'b0;
  logic          m_skew = 1'b0;

  function automatic logic [RW-1:0] mkrow(input int n);
    return {16'(n) + 16'h0300, 16'(n) + 16'h0200, 16'(n) + 16'h0100};
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < NC; i++) begin
      hist_m[i] = '0;
      hist_d[i] = '0;
    end
  endtask

  // One clock: start a new skewed row (optional), drive ready, update model.
  task automatic cycle(input logic [NC-1:0] mask, input logic [RW-1:0] row,
                       input logic rdy);
    logic pop;
    for (int i = NC - 1; i > 0; i--) begin
      hist_m[i] = hist_m[i-1];
      hist_d[i] = hist_d[i-1];
    end
    hist_m[0] = mask;
    hist_d[0] = row;
    for (int c = 0; c < NC; c++) begin
      col_valid[c]         = hist_m[c][c];
      col_data[c*AW +: AW] = hist_m[c][c] ? hist_d[c][c*AW +: AW] : 16'h0;
    end
    rd_ready = rdy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_skew = 1'b0;
    end else begin
      pop = (q.size() != 0) && rdy;
      if (pop) void'(q.pop_front());
      if (hist_m[NC-1] == '1) begin
        if (q.size() < DEPTH) q.push_back(hist_d[NC-1]);
        else m_ovf = 1'b1;
      end else if (hist_m[NC-1] != '0) begin
        m_skew = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clear_hist();
    rst = 1'b1;
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rd_valid !== 1'b0 || count !== '0 || rd_data !== '0 || overflow !== 1'b0 || full !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got v=%b cnt=%0d d=%h ovf=%b full=%b exp all zero",
                 k, rd_valid, count, rd_data, overflow, full);
      end
      cycle('0, '0, 1'b1);
    end
  endtask

  task automatic test_single_row();
    do_reset();
    cycle('1, 48'h0033_0022_0011, 1'b0);
    for (int k = 0; k < NC - 1; k++) begin
      total++;
      if (rd_valid !== 1'b0) begin
        bad++;
        $display("FAIL single_early k=%0d got v=%b exp 0", k, rd_valid);
      end
      cycle('0, '0, 1'b0);
    end
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 48'h0033_0022_0011 || count !== 3'd1) begin
      bad++;
      $display("FAIL single_row got v=%b d=%h cnt=%0d exp v=1 d=003300220011 cnt=1",
               rd_valid, rd_data, count);
    end
    cycle('0, '0, 1'b1);
    total++;
    if (count !== 3'd0 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pop got cnt=%0d v=%b exp 0 0", count, rd_valid);
    end
  endtask

  task automatic test_fill_wrap();
    do_reset();
    for (int n = 1; n <= 4; n++) cycle('1, mkrow(n), 1'b0);
    for (int k = 0; k < NC - 1; k++) cycle('0, '0, 1'b0);
    total++;
    if (full !== 1'b1 || count !== 3'd4) begin
      bad++;
      $display("FAIL fill_full got full=%b cnt=%0d exp 1 4", full, count);
    end
    for (int n = 1; n <= 2; n++) begin
      total++;
      if (rd_data !== mkrow(n)) begin
        bad++;
        $display("FAIL wrap_read n=%0d got %h exp %h", n, rd_data, mkrow(n));
      end
      cycle('0, '0, 1'b1);
    end
    cycle('1, mkrow(5), 1'b0);
    cycle('1, mkrow(6), 1'b0);
    for (int k = 0; k < NC - 1; k++) cycle('0, '0, 1'b0);
    total++;
    if (count !== 3'd4) begin
      bad++;
      $display("FAIL wrap_count got %0d exp 4", count);
    end
    for (int n = 3; n <= 6; n++) begin
      total++;
      if (rd_valid !== 1'b1 || rd_data !== mkrow(n)) begin
        bad++;
        $display("FAIL wrap_read n=%0d got v=%b d=%h exp %h", n, rd_valid, rd_data, mkrow(n));
      end
      cycle('0, '0, 1'b1);
    end
    total++;
    if (count !== 3'd0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL wrap_empty got cnt=%0d ovf=%b exp 0 0", count, overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int n = 1; n <= 4; n++) cycle('1, mkrow(n), 1'b0);
    cycle('1, 48'h00AA_00AA_00AA, 1'b0);
    for (int k = 0; k < NC; k++) cycle('0, '0, 1'b0);
    total++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      bad++;
      $display("FAIL overflow_set got ovf=%b cnt=%0d exp 1 4", overflow, count);
    end
    for (int n = 1; n <= 4; n++) begin
      total++;
      if (rd_data !== mkrow(n) || overflow !== 1'b1) begin
        bad++;
        $display("FAIL overflow_read n=%0d got d=%h ovf=%b exp %h 1", n, rd_data, overflow, mkrow(n));
      end
      cycle('0, '0, 1'b1);
    end
    total++;
    if (rd_valid !== 1'b0 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky got v=%b ovf=%b exp 0 1", rd_valid, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int n = 1; n <= 4; n++) cycle('1, mkrow(n), 1'b0);
    cycle('1, mkrow(7), 1'b0);
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b1);
    total++;
    if (count !== 3'd4 || overflow !== 1'b0 || rd_data !== mkrow(2)) begin
      bad++;
      $display("FAIL full_push_pop got cnt=%0d ovf=%b d=%h exp 4 0 %h", count, overflow, rd_data, mkrow(2));
    end
    for (int n = 2; n <= 5; n++) begin
      total++;
      if (rd_data !== mkrow(n == 5 ? 7 : n)) begin
        bad++;
        $display("FAIL full_pp_read n=%0d got %h exp %h", n, rd_data, mkrow(n == 5 ? 7 : n));
      end
      cycle('0, '0, 1'b1);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    cycle('1, mkrow(8), 1'b0);
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b0);
    cycle('1, mkrow(9), 1'b0);
    do_reset();
    for (int k = 0; k < NC + 1; k++) begin
      total++;
      if (count !== 3'd0 || rd_valid !== 1'b0 || rd_data !== '0) begin
        bad++;
        $display("FAIL midstream_reset k=%0d got cnt=%0d v=%b d=%h exp 0 0 0", k, count, rd_valid, rd_data);
      end
      cycle('0, '0, 1'b0);
    end
  endtask

  task automatic test_back_to_back_random();
    logic [RW-1:0] r;
    logic [NC-1:0] m;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      r[31:0]  = $urandom();
      r[47:32] = 16'($urandom());
      m        = ($urandom_range(0, 9) < 6) ? '1 : '0;
      cycle(m, r, 1'($urandom_range(0, 1)));
      total++;
      if (count !== 3'(q.size()) || rd_valid !== (q.size() != 0) || overflow !== m_ovf ||
          full !== (q.size() == DEPTH) || (q.size() != 0 && rd_data !== q[0])) begin
        bad++;
        $display("FAIL random k=%0d got cnt=%0d v=%b d=%h ovf=%b exp cnt=%0d ovf=%b head=%h",
                 k, count, rd_valid, rd_data, overflow, q.size(), m_ovf,
                 (q.size() != 0) ? q[0] : '0);
      end
    end
  endtask

`ifdef OUTBUF_SKEW_CHECK_EN
  task automatic test_skew();
    do_reset();
    cycle(3'b011, mkrow(3), 1'b0);
    cycle('0, '0, 1'b0);
    total++;
    if (skew_err !== 1'b0) begin
      bad++;
      $display("FAIL skew_early got %b exp 0", skew_err);
    end
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b0);
    total++;
    if (skew_err !== m_skew || skew_err !== 1'b1 || count !== 3'd0) begin
      bad++;
      $display("FAIL skew_set got err=%b cnt=%0d exp 1 0", skew_err, count);
    end
    do_reset();
    total++;
    if (skew_err !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL skew_reset got err=%b cnt=%0d exp 0 0", skew_err, count);
    end
  endtask
`endif

  initial begin
    clear_hist();
    test_reset();
    test_single_row();
    test_fill_wrap();
    test_overflow();
    test_full_push_pop();
    test_reset_midstream();
    test_back_to_back_random();
`ifdef OUTBUF_SKEW_CHECK_EN
    test_skew();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
